// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

   typedef enum logic {
      IDLE,
      CALC
   } state_e;

   typedef enum logic [2:0] {
      ZERO,
      PLUS1,
      PLUS2,
      MINUS1,
      MINUS2
   } booth_digit_e;

   // Operands are extended by two bits, so both modes need width/2 + 1 digits.
   function automatic int booth_steps(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps the multiplier triplet {x[2k+1], x[2k], x[2k-1]}
// onto a signed digit in {-2, -1, 0, +1, +2}.
module booth_r4_encoder
   import booth_pkg::*;
(
   input  logic [2:0] triplet,
   output logic [2:0] digit
);

   booth_digit_e digit_e;

   always_comb begin
      // NOTE: default first so every path assigns digit_e and no latch is inferred.
      digit_e = ZERO;
      case (triplet)
         3'b001, 3'b010: digit_e = PLUS1;
         3'b011:         digit_e = PLUS2;
         3'b100:         digit_e = MINUS2;
         3'b101, 3'b110: digit_e = MINUS1;
         default:        digit_e = ZERO;
      endcase
   end

   assign digit = digit_e;

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per clock,
// signed or unsigned per operation, start/busy/done handshake.
module booth_radix4_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   Z
);

   localparam int N  = booth_steps(WIDTH);
   localparam int CW = $clog2(N);
   localparam int AW = WIDTH + 3;          // accumulator: covers +/-2Y
   localparam int XW = WIDTH + 2;          // extended multiplier
   localparam int PW = AW + XW + 1;        // {acc, x, x[-1]}
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
   end

   state_e        state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] acc;
   logic [XW-1:0] xr;
   logic          x_1;
   logic [AW-1:0] yr;

   logic [2:0]    digit_bits;
   booth_digit_e  digit;
   logic [AW-1:0] addend;
   logic [AW-1:0] sum;
   logic [PW-1:0] shifted;

   booth_r4_encoder u_encoder (
      .triplet (({xr[1:0], x_1})),
      .digit   (digit_bits)
   );

   assign digit = booth_digit_e'(digit_bits);

   always_comb begin
      addend = '0;
      case (digit)
         PLUS1:   addend = yr;
         PLUS2:   addend = yr << 1;
         MINUS1:  addend = -yr;
         MINUS2:  addend = -(yr << 1);
         default: addend = '0;
      endcase
   end

   assign sum     = acc + addend;
   assign shifted = PW'($signed({sum, xr, x_1}) >>> 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Z     <= '0;
         cnt   <= '0;
         acc   <= '0;
         xr    <= '0;
         x_1   <= 1'b0;
         yr    <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every register sees pre-edge values.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  xr    <= signed_mode ? {{2{X[WIDTH-1]}}, X} : {2'b00, X};
                  yr    <= signed_mode ? {{3{Y[WIDTH-1]}}, Y} : {3'b000, Y};
                  acc   <= '0;
                  x_1   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= shifted[PW-1 -: AW];
               xr  <= shifted[XW:1];
               x_1 <= shifted[0];
               if (cnt == LAST) begin
                  // After the last shift the product sits in {acc, x}.
                  Z     <= shifted[2*WIDTH:1];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench for booth_radix4_multiplier at WIDTH 8 and 16.
module tb_booth_radix4_multiplier;

   localparam int N8  = 5;
   localparam int N16 = 9;

   typedef struct {
      logic [31:0] z;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, sm8, busy8, done8;
   logic [7:0]  x8, y8;
   logic [15:0] z8;
   logic        start16, sm16, busy16, done16;
   logic [15:0] x16, y16;
   logic [31:0] z16;

   exp_t        q8[$];
   exp_t        q16[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] prev8;
   logic [31:0] prev16;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   booth_radix4_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .X(x8), .Y(y8), .busy(busy8), .done(done8), .Z(z8)
   );

   booth_radix4_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .X(x16), .Y(y16), .busy(busy16), .done(done16), .Z(z16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: pop the scoreboard whenever done pulses, check Z and latency.
   always @(negedge clk) begin
      if (rst) begin
         prev8 = z8;
      end else begin
         check("busy_done_excl8", 32'(busy8 & done8), 32'd0);
         if (done8) begin
            check("done8_pending", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
               exp_t e;
               e = q8.pop_front();
               check("z8", 32'(z8), e.z);
               check("latency8", 32'(cyc - e.c), 32'(N8));
            end
         end else begin
            check("z8_hold", 32'(z8), 32'(prev8));
         end
         prev8 = z8;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev16 = z16;
      end else begin
         check("busy_done_excl16", 32'(busy16 & done16), 32'd0);
         if (done16) begin
            check("done16_pending", 32'(q16.size() > 0), 32'd1);
            if (q16.size() > 0) begin
               exp_t e;
               e = q16.pop_front();
               check("z16", z16, e.z);
               check("latency16", 32'(cyc - e.c), 32'(N16));
            end
         end else begin
            check("z16_hold", z16, prev16);
         end
         prev16 = z16;
      end
   end

   // Called at a negedge: start is seen at the next posedge (E0).
   task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                         input logic [15:0] ez);
      start8 = 1'b1; x8 = x; y8 = y; sm8 = sm;
      q8.push_back('{z: 32'(ez), c: cyc + 1});
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic sm,
                          input logic [31:0] ez);
      start16 = 1'b1; x16 = x; y16 = y; sm16 = sm;
      q16.push_back('{z: ez, c: cyc + 1});
      @(negedge clk);
      start16 = 1'b0;
   endtask

   task automatic wait_done8();
      int n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("done8_seen", 32'(done8), 32'd1);
   endtask

   task automatic wait_done16();
      int n = 0;
      while (!done16 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("done16_seen", 32'(done16), 32'd1);
   endtask

   // {X, Y, signed_mode, expected Z}, hand-computed.
   logic [7:0]  vx [8] = '{8'h03, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h00, 8'hA5, 8'hA5};
   logic [7:0]  vy [8] = '{8'hFB, 8'hFF, 8'h7F, 8'h7F, 8'h80, 8'hA5, 8'h3C, 8'h3C};
   logic        vs [8] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
   logic [15:0] vz [8] = '{16'hFFF1, 16'h0001, 16'h3F01, 16'hC080,
                           16'h4000, 16'h0000, 16'h26AC, 16'hEAAC};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
      start16 = 1'b0; sm16 = 1'b0; x16 = '0; y16 = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_busy8", 32'(busy8), 32'd0);
      check("reset_done8", 32'(done8), 32'd0);
      check("reset_z8", 32'(z8), 32'd0);
      check("reset_z16", z16, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue8(8'h80, 8'h80, 1'b1, 16'h4000);
      wait_done8();
      @(negedge clk);
      issue8(8'h7F, 8'hFF, 1'b1, 16'hFF81);
      wait_done8();
      @(negedge clk);
      issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
      wait_done8();
      issue8(8'hFF, 8'h01, 1'b0, 16'h00FF);   // back-to-back in the done cycle
      wait_done8();
      for (int i = 0; i < 8; i++) begin
         issue8(vx[i], vy[i], vs[i], vz[i]);
         wait_done8();
      end

      // Restart attempts and operand changes while busy must be ignored.
      @(negedge clk);
      issue8(8'h11, 8'h22, 1'b0, 16'h0242);
      start8 = 1'b1; x8 = 8'h33; y8 = 8'h44; sm8 = 1'b1;
      @(negedge clk);
      x8 = 8'h55;
      @(negedge clk);
      start8 = 1'b0; x8 = 8'h66;
      wait_done8();
      repeat (10) @(negedge clk);
      check("single_done8", 32'(q8.size()), 32'd0);

      // Reset at cycle 3 of an operation aborts it.
      issue8(8'h12, 8'h34, 1'b0, 16'h03A8);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy8", 32'(busy8), 32'd0);
      check("abort_done8", 32'(done8), 32'd0);
      check("abort_z8", 32'(z8), 32'd0);
      void'(q8.pop_back());
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      issue8(8'h12, 8'h34, 1'b0, 16'h03A8);
      wait_done8();

      @(negedge clk);
      issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
      wait_done16();
      issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      wait_done16();
      issue16(16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD);
      wait_done16();

      repeat (12) @(negedge clk);
      check("drained8", 32'(q8.size()), 32'd0);
      check("drained16", 32'(q16.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
